// File: rtl/regfile_sb_pkg.sv
// Shared widths and constants for the RV32I register file and its scoreboard.
package regfile_sb_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned RegNum     = 32;
  localparam int unsigned RegNumLog2 = 5;

  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Write-reservation scoreboard: one busy bit per register plus per-port hazard flags.
module regfile_scoreboard
  import regfile_sb_pkg::*;
#(
  parameter int unsigned ADDR_W = RegNumLog2,
  parameter int unsigned NREGS  = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r1_enable_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic              r2_enable_i,
  input  logic [ADDR_W-1:0] r2_addr_i,
  input  logic              w_enable_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic              issue_enable_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic [NREGS-1:0]  busy_o,
  output logic              hazard1_o,
  output logic              hazard2_o
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_nxt;
  logic             w_wr;
  logic             w_byp1;
  logic             w_byp2;

  assign w_wr = (w_enable_i == WriteEnable);

  // A younger issue wins over a same-cycle writeback clearing the same register.
  always_comb begin
    w_busy_nxt = r_busy;
    if (flush_i) begin
      w_busy_nxt = '0;
    end else begin
      for (int unsigned k = 1; k < NREGS; k++) begin
        if (issue_enable_i && !stall_i && (issue_addr_i == ADDR_W'(k)))
          w_busy_nxt[k] = 1'b1;
        else if (w_wr && (w_addr_i == ADDR_W'(k)))
          w_busy_nxt[k] = 1'b0;
      end
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  assign w_byp1 = w_wr && (w_addr_i == r1_addr_i);
  assign w_byp2 = w_wr && (w_addr_i == r2_addr_i);

  assign hazard1_o = r1_enable_i && (r1_addr_i != ADDR_W'(NOPRegAddr)) && r_busy[r1_addr_i] && !w_byp1;
  assign hazard2_o = r2_enable_i && (r2_addr_i != ADDR_W'(NOPRegAddr)) && r_busy[r2_addr_i] && !w_byp2;
  assign busy_o    = r_busy;

endmodule

// File: rtl/regfile_sb.sv
// RV32I architectural register file with write-first bypass and operand-hazard stall.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int unsigned DATA_W = RegBus,
  parameter int unsigned ADDR_W = RegAddrBus,
  parameter int unsigned NREGS  = RegNum
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r1_enable_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  output logic [DATA_W-1:0] r1_data_o,
  input  logic              r2_enable_i,
  input  logic [ADDR_W-1:0] r2_addr_i,
  output logic [DATA_W-1:0] r2_data_o,
  input  logic              w_enable_i,
  input  logic [ADDR_W-1:0] w_addr_i,
  input  logic [DATA_W-1:0] w_data_i,
  input  logic              issue_enable_i,
  input  logic [ADDR_W-1:0] issue_addr_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic [NREGS-1:0]  busy_o
);

  logic [DATA_W-1:0] r_regs [NREGS];
  logic              w_wr;
  logic              w_hazard1;
  logic              w_hazard2;
  logic              w_stall;
  logic [NREGS-1:0]  w_busy;

  assign w_wr = (w_enable_i == WriteEnable) && (w_addr_i != ADDR_W'(NOPRegAddr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[w_addr_i] <= w_data_i;
    end
  end

  // Outputs are gated by reset so the bypass path cannot leak write data while held.
  always_comb begin
    r1_data_o = DATA_W'(ZeroWord);
    if (rst && r1_enable_i && (r1_addr_i != ADDR_W'(NOPRegAddr)))
      r1_data_o = (w_wr && (w_addr_i == r1_addr_i)) ? w_data_i : r_regs[r1_addr_i];
  end

  always_comb begin
    r2_data_o = DATA_W'(ZeroWord);
    if (rst && r2_enable_i && (r2_addr_i != ADDR_W'(NOPRegAddr)))
      r2_data_o = (w_wr && (w_addr_i == r2_addr_i)) ? w_data_i : r_regs[r2_addr_i];
  end

  assign w_stall = rst && (w_hazard1 || w_hazard2);
  assign stall_o = w_stall;
  assign busy_o  = w_busy;

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .NREGS  (NREGS)
  ) u_scoreboard (
    .clk            (clk),
    .rst            (rst),
    .r1_enable_i    (r1_enable_i),
    .r1_addr_i      (r1_addr_i),
    .r2_enable_i    (r2_enable_i),
    .r2_addr_i      (r2_addr_i),
    .w_enable_i     (w_enable_i),
    .w_addr_i       (w_addr_i),
    .issue_enable_i (issue_enable_i),
    .issue_addr_i   (issue_addr_i),
    .flush_i        (flush_i),
    .stall_i        (w_stall),
    .busy_o         (w_busy),
    .hazard1_o      (w_hazard1),
    .hazard2_o      (w_hazard2)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        r1_enable_i, r2_enable_i, w_enable_i, issue_enable_i, flush_i;
  logic [4:0]  r1_addr_i, r2_addr_i, w_addr_i, issue_addr_i;
  logic [31:0] r1_data_o, r2_data_o, w_data_i;
  logic        stall_o;
  logic [31:0] busy_o;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREGS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .r1_enable_i    (r1_enable_i),
    .r1_addr_i      (r1_addr_i),
    .r1_data_o      (r1_data_o),
    .r2_enable_i    (r2_enable_i),
    .r2_addr_i      (r2_addr_i),
    .r2_data_o      (r2_data_o),
    .w_enable_i     (w_enable_i),
    .w_addr_i       (w_addr_i),
    .w_data_i       (w_data_i),
    .issue_enable_i (issue_enable_i),
    .issue_addr_i   (issue_addr_i),
    .flush_i        (flush_i),
    .stall_o        (stall_o),
    .busy_o         (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    r1_enable_i = 0; r1_addr_i = 0; r2_enable_i = 0; r2_addr_i = 0;
    w_enable_i = 0; w_addr_i = 0; w_data_i = 0;
    issue_enable_i = 0; issue_addr_i = 0; flush_i = 0;

    // Write attempted while reset is held must be dropped
    w_enable_i = 1; w_addr_i = 5'd3; w_data_i = 32'hDEADBEEF;
    r1_enable_i = 1; r1_addr_i = 5'd3;
    tick(); tick();
    chk("rst_r1_forced", r1_data_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_busy", busy_o, 32'h0);
    w_enable_i = 0;
    rst = 1'b1;
    #1;
    chk("post_rst_x3", r1_data_o, 32'h0);

    // x0 write is discarded, also on the bypass path
    w_enable_i = 1; w_addr_i = 5'd0; w_data_i = 32'h12345678;
    r1_addr_i = 5'd0;
    #1;
    chk("x0_bypass", r1_data_o, 32'h0);
    tick();
    w_enable_i = 0;
    #1;
    chk("x0_read", r1_data_o, 32'h0);

    // Write x5, read on both ports next cycle
    w_enable_i = 1; w_addr_i = 5'd5; w_data_i = 32'h0000ABCD;
    tick();
    w_enable_i = 0;
    r1_addr_i = 5'd5; r2_enable_i = 1; r2_addr_i = 5'd5;
    #1;
    chk("x5_r1", r1_data_o, 32'h0000ABCD);
    chk("x5_r2", r2_data_o, 32'h0000ABCD);
    chk("x5_stall", {31'b0, stall_o}, 32'h0);

    // Write-first bypass before the edge, then committed value after
    w_enable_i = 1; w_addr_i = 5'd7; w_data_i = 32'h55AA55AA;
    r2_addr_i = 5'd7;
    #1;
    chk("byp_r2", r2_data_o, 32'h55AA55AA);
    chk("byp_r1_other", r1_data_o, 32'h0000ABCD);
    tick();
    w_enable_i = 0;
    #1;
    chk("x7_commit", r2_data_o, 32'h55AA55AA);
    r1_enable_i = 0; r2_enable_i = 0;
    #1;
    chk("disabled_r2", r2_data_o, 32'h0);

    // Scoreboard: issue x9, stalled read blocks a concurrent issue to x10
    issue_enable_i = 1; issue_addr_i = 5'd9;
    tick();
    issue_enable_i = 0;
    #1;
    chk("busy9_set", busy_o, 32'h0000_0200);
    r1_enable_i = 1; r1_addr_i = 5'd9;
    issue_enable_i = 1; issue_addr_i = 5'd10;
    #1;
    chk("stall_x9", {31'b0, stall_o}, 32'h1);
    tick();
    issue_enable_i = 0;
    #1;
    chk("issue10_ignored", busy_o, 32'h0000_0200);
    w_enable_i = 1; w_addr_i = 5'd9; w_data_i = 32'h00000042;
    #1;
    chk("wb9_nostall", {31'b0, stall_o}, 32'h0);
    chk("wb9_bypass", r1_data_o, 32'h00000042);
    tick();
    w_enable_i = 0;
    #1;
    chk("busy9_clear", busy_o, 32'h0);
    chk("x9_commit", r1_data_o, 32'h00000042);
    r1_enable_i = 0;

    // Same-cycle set and clear of x4: set wins, data still commits
    issue_enable_i = 1; issue_addr_i = 5'd4;
    tick();
    chk("busy4_set", busy_o, 32'h0000_0010);
    w_enable_i = 1; w_addr_i = 5'd4; w_data_i = 32'h44444444;
    tick();
    issue_enable_i = 0; w_enable_i = 0;
    r1_enable_i = 1; r1_addr_i = 5'd4;
    #1;
    chk("busy4_kept", busy_o, 32'h0000_0010);
    chk("x4_data", r1_data_o, 32'h44444444);
    chk("x4_stall", {31'b0, stall_o}, 32'h1);
    r1_enable_i = 0;
    #1;

    // Flush drops every reservation and ignores a same-cycle issue
    issue_enable_i = 1; issue_addr_i = 5'd1;
    tick();
    issue_addr_i = 5'd2;
    tick();
    issue_addr_i = 5'd31;
    tick();
    issue_enable_i = 0;
    chk("busy_multi", busy_o, 32'h8000_0016);
    flush_i = 1; issue_enable_i = 1; issue_addr_i = 5'd6;
    tick();
    flush_i = 0; issue_enable_i = 0;
    #1;
    chk("flush_busy", busy_o, 32'h0);

    // Asynchronous reset between edges
    issue_enable_i = 1; issue_addr_i = 5'd8;
    tick();
    issue_enable_i = 0;
    chk("busy8_set", busy_o, 32'h0000_0100);
    r1_enable_i = 1; r1_addr_i = 5'd5;
    r2_enable_i = 1; r2_addr_i = 5'd8;
    w_enable_i = 1; w_addr_i = 5'd8; w_data_i = 32'hCAFEF00D;
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", busy_o, 32'h0);
    chk("arst_r1", r1_data_o, 32'h0);
    chk("arst_r2_bypass_gated", r2_data_o, 32'h0);
    chk("arst_stall", {31'b0, stall_o}, 32'h0);
    w_enable_i = 0;
    #1;
    rst = 1'b1;
    r2_addr_i = 5'd7;
    #1;
    chk("arst_x5_cleared", r1_data_o, 32'h0);
    chk("arst_x7_cleared", r2_data_o, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Architectural integer register file for the RV32I pipeline, with a write-reservation scoreboard.
- It is the responder to the decode stage's two read-request ports (enable, address in; data out).
- It accepts the writeback-stage write port.
- It tracks registers that have an issued but not yet written-back result, and raises stall_o when decode reads one of them before its data is available.

Parameters:
- DATA_W, 32, register width (equals RegBus).
- ADDR_W, 5, register address width (equals RegAddrBus).
- NREGS, 32, number of registers; must equal 2**ADDR_W.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- r1_enable_i  in  1  read port 1 request from decode
- r1_addr_i  in  ADDR_W  read port 1 register index
- r1_data_o  out  DATA_W  read port 1 data
- r2_enable_i  in  1  read port 2 request from decode
- r2_addr_i  in  ADDR_W  read port 2 register index
- r2_data_o  out  DATA_W  read port 2 data
- w_enable_i  in  1  writeback write strobe
- w_addr_i  in  ADDR_W  writeback destination
- w_data_i  in  DATA_W  writeback data
- issue_enable_i  in  1  decode is issuing an instruction that writes a register
- issue_addr_i  in  ADDR_W  destination of the issuing instruction
- flush_i  in  1  pipeline flush; drops all reservations
- stall_o  out  1  decode must hold; a requested operand is pending
- busy_o  out  NREGS  scoreboard bit vector, for debug and verification

Behaviour:
- Reset (rst=0, asynchronous):
  - All NREGS data registers clear to 0.
  - All busy bits clear to 0.
  - While reset is held, r1_data_o, r2_data_o and stall_o are forced to 0 and busy_o is 0.
- Register x0:
  - Always reads 0.
  - Writes to x0 are discarded.
  - Issues to x0 never set busy[0], so busy[0] is permanently 0.
- Write:
  - At a rising edge with w_enable_i=1 and w_addr_i!=0, reg[w_addr_i] <= w_data_i.
  - The write is committed one cycle after presentation.
- Read (combinational, zero latency), per port p:
  - If enable=0: data is 0.
  - Else if addr=0: data is 0.
  - Else if w_enable_i=1 and w_addr_i==addr: data is w_data_i (write-first bypass).
  - Else: data is reg[addr].
- Operand hazard, per port p:
  - hazard_p = enable & (addr!=0) & busy[addr] & ~(w_enable_i & w_addr_i==addr).
  - A writeback arriving in the same cycle satisfies the read through the bypass, so no stall.
  - stall_o = hazard_1 | hazard_2.
  - stall_o is purely combinational and does not depend on issue_enable_i, so there is no loop.
- Scoreboard update (rising edge, per register k, priority high to low):
  1. flush_i=1: busy[k] <= 0 for all k. A same-cycle issue is ignored; a same-cycle write still commits data.
  2. Set: issue_enable_i=1, stall_o=0, issue_addr_i==k, k!=0 → busy[k] <= 1. Set wins over a same-cycle clear of the same k, because the new issue is younger.
  3. Clear: w_enable_i=1 and w_addr_i==k → busy[k] <= 0.
  4. Otherwise: hold.
- Issue while stall_o=1 is ignored; decode re-presents it next cycle.
- A writeback to a non-busy register is legal: data is written and busy stays 0.
- A second issue to an already busy register is legal: the bit stays 1, and the first writeback clears it. The single outstanding write per register is guaranteed by the in-order pipeline.

Decomposition:
- Widths and constants come from Defines.vh: RegBus, RegAddrBus, ZeroWord, WriteEnable, WriteDisable, NOPRegAddr.
- Add to Defines.vh: RegNum (32) and the RegNumLog2 alias.
- One sub-module, regfile_scoreboard. It holds the busy vector with its set/clear/flush logic and produces hazard flags for both ports.
- The top level holds the storage array, the bypass muxes and the stall OR.

Test Plan:
- Reset and x0 check:
  - Hold rst=0 and drive w_enable_i=1, addr 3, data 0xDEADBEEF → no write; r1_data_o=0 after release with r1 addr 3.
  - Write x0=0x12345678 → reading x0 returns 0.
- Write then read: write x5=0x0000ABCD at edge N → at N+1, r1 addr 5 and r2 addr 5 both return 0x0000ABCD, stall_o=0.
- Bypass: in the same cycle, w_enable_i=1, addr 7, data 0x55AA55AA and r2 addr 7 → r2_data_o=0x55AA55AA combinationally, before the edge.
- Scoreboard stall:
  - Issue to x9 → busy_o[9]=1.
  - Next cycle, r1 enable with addr 9 and no writeback → stall_o=1, and a concurrent issue to x10 is ignored (busy_o[10]=0).
  - Writeback x9=0x00000042 → same cycle stall_o=0 and r1_data_o=0x42; busy_o[9]=0 next cycle.
- Simultaneous set and clear: busy[4]=1, then in one cycle writeback x4 and issue x4 → after the edge busy_o[4]=1 and reg[4] holds the written value.
- Flush and mid-operation reset:
  - With busy x1, x2, x31 set, flush_i=1 plus issue x6 → all busy_o bits 0.
  - Then set busy x8 and pulse rst=0 between edges → busy_o=0 and all registers read 0 immediately, with no clock edge needed.
